// File: rtl/cdc_cmd_launcher.sv
// Source-domain command launcher: queues command words in a small FIFO and
// presents each one as a registered word plus a one-cycle enable pulse, held for HOLD_CYCLES clocks.
module cdc_cmd_launcher #(
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [DATA_WIDTH-1:0]              s_data,
    input  logic                               flush,
    output logic                               en_out,
    output logic [DATA_WIDTH-1:0]              data_out,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH+1);
    localparam int CW = $clog2(HOLD_CYCLES);
    // HOLD spans HOLD_CYCLES cycles including the pulse cycle itself.
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [CW-1:0]         r_cnt;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_launch;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // A flush drops any same-cycle push, so the FIFO is guaranteed empty afterwards.
    assign w_push  = s_valid && !w_full && !flush;

    assign s_ready    = !w_full;
    assign en_out     = r_en;
    assign data_out   = r_data;
    assign busy       = (r_state == HOLD) || !w_empty;
    assign fifo_level = LW'(r_wr_ptr - r_rd_ptr);

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_launch    = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (r_cnt == '0) begin
                    if (!w_empty) w_launch = 1'b1;
                    else          w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_en     <= 1'b0;
            r_data   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_en    <= w_launch;
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (flush)         r_rd_ptr <= r_wr_ptr;
            else if (w_launch) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            if (w_launch) begin
                r_data <= r_mem[r_rd_ptr[AW-1:0]];
                r_cnt  <= HOLD_LOAD;
            end else if (r_state == HOLD && r_cnt != '0) begin
                r_cnt  <= r_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= s_data;
    end
endmodule

// File: tb/tb_cdc_cmd_launcher.sv
// Scoreboard bench for cdc_cmd_launcher: accepted words are queued and
// compared against each en_out pulse; timing, flush and reset cases are directed.
module tb_cdc_cmd_launcher;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int HOLD  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          flush;
    logic          en_out;
    logic [DW-1:0] data_out;
    logic          busy;
    logic [2:0]    fifo_level;

    cdc_cmd_launcher #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .flush(flush), .en_out(en_out), .data_out(data_out),
        .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int            n_chk = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q[$];
    int            pulse_t[$];
    int            cyc = 0;
    int            last_pulse = -1;
    int            npulse = 0;
    int            max_lvl = 0;
    bit            saw_nr = 0;
    logic [DW-1:0] last_data = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Output monitor: every pulse must match the scoreboard head.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            last_pulse = -1;
            last_data  = '0;
        end else begin
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
            if (en_out) begin
                if (exp_q.size() == 0) chk("pulse_expected", en_out, 0);
                else                   chk("data_order", data_out, exp_q.pop_front());
                if (last_pulse >= 0) chk("spacing_min", (cyc - last_pulse) >= HOLD, 1);
                last_pulse = cyc;
                npulse++;
                pulse_t.push_back(cyc);
                last_data = data_out;
            end else begin
                chk("data_hold", data_out, last_data);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        bit ok;
        ok      = 0;
        s_valid = 1'b1;
        s_data  = w;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (!s_ready) saw_nr = 1;
            ok = s_ready && !flush;
            tick(1);
        end
        s_valid = 1'b0;
        chk("push_accept", ok, 1);
        if (ok) exp_q.push_back(w);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000 && (busy || exp_q.size() != 0); i++) tick(1);
        chk("idle_timeout", busy, 0);
        chk("sb_drained", exp_q.size(), 0);
    endtask

    int np0;

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        flush   = 1'b0;
        #12;
        chk("rst_en_out", en_out, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(3);

        // Single word: latency and hold window
        np0 = npulse;
        push(32'hA5A5_0001);
        chk("single_en_early", en_out, 0);
        chk("single_lvl1", fifo_level, 1);
        chk("single_busy_q", busy, 1);
        tick(1);
        chk("single_en", en_out, 1);
        chk("single_data", data_out, 32'hA5A5_0001);
        chk("single_lvl0", fifo_level, 0);
        tick(15);
        chk("single_busy_hold", busy, 1);
        chk("single_en_off", en_out, 0);
        tick(1);
        chk("single_busy_end", busy, 0);
        chk("single_data_kept", data_out, 32'hA5A5_0001);
        chk("single_count", npulse - np0, 1);
        tick(5);

        // Burst of 6: backpressure, exact spacing, order
        np0 = npulse; pulse_t.delete(); max_lvl = 0; saw_nr = 0;
        for (int i = 0; i < 6; i++) push(32'hB000_0000 + i);
        wait_idle();
        chk("burst_count", npulse - np0, 6);
        chk("burst_backpressure", saw_nr, 1);
        chk("burst_lvl_max", max_lvl, DEPTH);
        for (int i = 1; i < pulse_t.size(); i++)
            chk("burst_spacing", pulse_t[i] - pulse_t[i-1], HOLD);
        tick(5);

        // Wrap: 12 words with random gaps
        np0 = npulse; max_lvl = 0;
        for (int i = 0; i < 12; i++) begin
            push(i);
            tick($urandom_range(0, 25));
        end
        wait_idle();
        chk("wrap_count", npulse - np0, 12);
        chk("wrap_lvl_bound", max_lvl <= DEPTH, 1);
        tick(5);

        // Flush mid-HOLD with 3 queued
        np0 = npulse;
        for (int i = 0; i < 4; i++) push(32'hF000_0000 + i);
        chk("flush_pre_lvl", fifo_level, 3);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        exp_q.delete();
        chk("flush_lvl", fifo_level, 0);
        chk("flush_data_held", data_out, 32'hF000_0000);
        chk("flush_s_ready", s_ready, 1);
        chk("flush_busy_hold", busy, 1);
        tick(12);
        chk("flush_busy_late", busy, 1);
        tick(1);
        chk("flush_busy_drop", busy, 0);
        tick(40);
        chk("flush_count", npulse - np0, 1);

        // Flush coinciding with a launch edge
        np0 = npulse;
        push(32'hC000_000A);
        push(32'hC000_000B);
        push(32'hC000_000C);
        tick(14);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        chk("coin_en", en_out, 1);
        chk("coin_data", data_out, 32'hC000_000B);
        chk("coin_lvl", fifo_level, 0);
        wait_idle();
        tick(40);
        chk("coin_count", npulse - np0, 2);

        // Asynchronous reset mid-HOLD with 3 queued
        for (int i = 0; i < 4; i++) push(32'hD000_0000 + i);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_en_out", en_out, 0);
        chk("arst_data_out", data_out, 0);
        chk("arst_s_ready", s_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_level", fifo_level, 0);
        tick(2);
        rst_n = 1'b1;
        np0 = npulse;
        tick(40);
        chk("arst_no_pulse", npulse - np0, 0);
        chk("arst_busy_after", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
